aes_inv_key_step: RTL and testbench



---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_inv_key_step_sbytes.sv | 29 ++
 rtl/aes_inv_key_step.sv | 106 ++++++++++
 tb/tb_aes_inv_key_step.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the reverse key-schedule step: widths,
// FSM state encoding and the round-constant lookup.
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int KEY_W  = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        FIN,
        DONE
    } state_t;

    // Legal rounds are 1..10; anything else yields 0 and never reaches FIN.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_inv_key_step_sbytes.sv
// Combinational forward AES S-box, one byte in, one byte out.
module sbytes (
    input  logic [7:0] olddata,
    output logic [7:0] newdata
);

    // Entry 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign newdata = SBOX[olddata];

endmodule

// File: rtl/aes_inv_key_step.sv
// Reverse AES-128 key-schedule step: K_r, r -> K_(r-1), one shared S-box
// used over four cycles. Optional AES_INV_KEY_CHAIN_EN adds a `chain` input.
module aes_inv_key_step
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
`ifdef AES_INV_KEY_CHAIN_EN
    input  logic             chain,
`endif
    input  logic [3:0]       round_in,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t            state;
    logic [KEY_W-1:0]  k;
    logic [3:0]        rnd;
    logic [3:0][7:0]   rot;
    logic [3:0][7:0]   t;
    logic [1:0]        cnt;
    logic              err_pend;

    logic [KEY_W-1:0]  sel_key;
    logic [3:0]        sel_rnd;
    logic              rnd_ok;
    logic [WORD_W-1:0] v3;
    logic [7:0]        sb_in;
    logic [7:0]        sb_out;

`ifdef AES_INV_KEY_CHAIN_EN
    // Chaining walks one round further back from the result just produced.
    assign sel_key = chain ? key_out : key_in;
    assign sel_rnd = chain ? rnd - 4'd1 : round_in;
`else
    assign sel_key = key_in;
    assign sel_rnd = round_in;
`endif

    assign rnd_ok = (sel_rnd != 4'd0) && (sel_rnd <= 4'(NUM_ROUNDS));
    assign v3     = k[31:0] ^ k[63:32];
    // Byte c of a word sits at packed index 3-c.
    assign sb_in  = rot[~cnt];

    sbytes u_sbox (
        .olddata (sb_in),
        .newdata (sb_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            k        <= '0;
            rnd      <= '0;
            rot      <= '0;
            t        <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            key_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    k        <= sel_key;
                    rnd      <= sel_rnd;
                    err_pend <= !rnd_ok;
                    err      <= 1'b0;
                    busy     <= 1'b1;
                    state    <= rnd_ok ? LOAD : DONE;
                end
                LOAD: begin
                    k     <= {k[127:96], k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], v3};
                    rot   <= {v3[23:0], v3[31:24]};
                    cnt   <= 2'd0;
                    state <= SUB;
                end
                SUB: begin
                    t[~cnt] <= sb_out;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= FIN;
                end
                FIN: begin
                    key_out <= {k[127:96] ^ t ^ {rcon(rnd), 24'h0}, k[95:0]};
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    err   <= err_pend;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_step.sv
// Directed bench for aes_inv_key_step: vector table plus reset, busy and
// chaining sequences (chaining only when AES_INV_KEY_CHAIN_EN is defined).
module tb_aes_inv_key_step;
    import aes_pkg::*;

    localparam logic [127:0] K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] K9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    localparam logic [127:0] K8  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    localparam logic [127:0] K1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   round_in = '0;
    logic [127:0] key_in = '0;
    logic [127:0] key_out;
    logic         busy, done, err;
`ifdef AES_INV_KEY_CHAIN_EN
    logic         chain = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    aes_inv_key_step #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
`ifdef AES_INV_KEY_CHAIN_EN
        .chain    (chain),
`endif
        .round_in (round_in),
        .key_in   (key_in),
        .key_out  (key_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then count negedges until done (bounded).
    task automatic do_op(input logic [127:0] key, input logic [3:0] r, input logic ch, output int lat);
        @(negedge clk);
        key_in   = key;
        round_in = r;
        start    = 1'b1;
`ifdef AES_INV_KEY_CHAIN_EN
        chain    = ch;
`endif
        @(negedge clk);
        start = 1'b0;
`ifdef AES_INV_KEY_CHAIN_EN
        chain = 1'b0;
`endif
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [127:0] exp_key;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        vecs[0] = '{K10, 4'd10, K9, 1'b0, 8};
        vecs[1] = '{K10, 4'd0,  K9, 1'b1, 2};
        vecs[2] = '{K10, 4'd11, K9, 1'b1, 2};
        vecs[3] = '{K9,  4'd9,  K8, 1'b0, 8};
        vecs[4] = '{K1,  4'd1,  K0, 1'b0, 8};
        vecs[5] = '{K8,  4'd15, K0, 1'b1, 2};

        // Reset and idle
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outputs", {key_out, busy, done, err}, {128'h0, 3'b000});
        end

        // Vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].key, vecs[i].rnd, 1'b0, lat);
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
            chk($sformatf("v%0d_key", i), key_out, vecs[i].exp_key);
            chk($sformatf("v%0d_err_busy", i), {126'h0, err, busy}, {126'h0, vecs[i].exp_err, 1'b0});
        end

        // Start while busy is ignored
        @(negedge clk);
        key_in = K9; round_in = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        key_in = K1; round_in = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_op", {127'h0, busy}, 128'h1);
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("ignore_latency", 128'(lat), 128'd8);
        chk("ignore_key", key_out, K8);
        chk("ignore_err", {127'h0, err}, 128'h0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) lat++;
        end
        chk("ignore_no_second_op", 128'(lat), 128'd0);

        // Reset during SUB wipes everything
        @(negedge clk);
        key_in = K10; round_in = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b1;
        round_in = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {key_out, busy, done, err}, {128'h0, 3'b000});
        @(negedge clk);
        n_rst = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || err || key_out != 0) lat++;
        end
        chk("rst_stays_idle", 128'(lat), 128'd0);
        do_op(K1, 4'd1, 1'b0, lat);
        chk("rst_after_latency", 128'(lat), 128'd8);
        chk("rst_after_key", key_out, K0);
        chk("rst_after_err", {127'h0, err}, 128'h0);

`ifdef AES_INV_KEY_CHAIN_EN
        // Walk from round 10 back to the cipher key
        do_op(K10, 4'd10, 1'b0, lat);
        chk("chain_first_key", key_out, K9);
        for (int i = 0; i < 9; i++) begin
            do_op(128'h0, 4'd0, 1'b1, lat);
            if (i == 0) chk("chain_step1_key", key_out, K8);
        end
        chk("chain_final_key", key_out, K0);
        chk("chain_final_err", {127'h0, err}, 128'h0);
        do_op(128'h0, 4'd5, 1'b1, lat);
        chk("chain_tenth_err", {127'h0, err}, 128'h1);
        chk("chain_tenth_latency", 128'(lat), 128'd2);
        chk("chain_tenth_key", key_out, K0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
